// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding select, load-use stall, mispredict flush,
// RUN/HALT control for syscalls, and cycle/stall/flush performance counters.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_r1,
    input  logic [4:0]  id_r2,
    input  logic        id_r1_use,
    input  logic        id_r2_use,
    input  logic        id_lo_r1,
    input  logic        id_lo_r2,
    input  logic [4:0]  ex_rw,
    input  logic        ex_we,
    input  logic        ex_ld,
    input  logic        ex_we_lo,
    input  logic [4:0]  mem_rw,
    input  logic        mem_we,
    input  logic        ex_mispredict,
    input  logic        ex_sys,
    input  logic        go,
    output logic        run,
    output logic        stall_fd,
    output logic        bubble,
    output logic        clear_u,
    output logic [5:0]  redirection,
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic r1_ok, r2_ok;
    logic ex_fwd1, ex_fwd2;
    logic mem_fwd1, mem_fwd2;
    logic lo_fwd1, lo_fwd2;
    logic load_use;
    logic running;

    // Operand qualification: unused operands and $0 never forward from the RF path.
    always_comb begin
        r1_ok    = id_r1_use && (id_r1 != 5'd0);
        r2_ok    = id_r2_use && (id_r2 != 5'd0);
        ex_fwd1  = r1_ok && ex_we && !ex_ld && (ex_rw == id_r1);
        ex_fwd2  = r2_ok && ex_we && !ex_ld && (ex_rw == id_r2);
        // EX holds the younger value, so it wins over MEM for the same operand.
        mem_fwd1 = r1_ok && mem_we && (mem_rw == id_r1) && !ex_fwd1;
        mem_fwd2 = r2_ok && mem_we && (mem_rw == id_r2) && !ex_fwd2;
        lo_fwd1  = id_r1_use && ex_we_lo && id_lo_r1;
        lo_fwd2  = id_r2_use && ex_we_lo && id_lo_r2;
        redirection = {lo_fwd2, lo_fwd1, mem_fwd2, mem_fwd1, ex_fwd2, ex_fwd1};
    end

    always_comb begin
        load_use = ex_ld && ex_we && (ex_rw != 5'd0) &&
                   ((id_r1_use && (ex_rw == id_r1)) ||
                    (id_r2_use && (ex_rw == id_r2)));
    end

    // Reset forces a flush with the pipeline frozen; mispredict flush beats the stall.
    always_comb begin
        running  = rst_n && (state == ST_RUN);
        run      = running;
        halted   = (state == ST_HALT);
        clear_u  = !rst_n || (running && ex_mispredict);
        bubble   = running && load_use && !ex_mispredict;
        stall_fd = bubble;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (ex_sys && !ex_mispredict) state_nxt = ST_HALT;
            ST_HALT: if (go) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == ST_RUN) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (bubble)  stall_cnt <= stall_cnt + 32'd1;
            if (clear_u) flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 clk  in  1  single clock for the block; all state updates on the rising edge.
REQ-002 rst_n  in  1  reset, synchronous and active-low.
REQ-003 id_r1, id_r2  in  5 each  source register numbers of the instruction in ID.
REQ-004 id_r1_use, id_r2_use  in  1 each  ID instruction reads r1 / r2.
REQ-005 id_lo_r1, id_lo_r2  in  1 each  ID operand 1 / 2 is sourced from LO.
REQ-006 ex_rw  in  5  destination of the instruction in EX.
REQ-007 ex_we, ex_ld, ex_we_lo  in  1 each  EX writes the RF / is a load / writes LO.
REQ-008 mem_rw  in  5  destination of the instruction in MEM.
REQ-009 mem_we  in  1  MEM writes the RF.
REQ-010 ex_mispredict  in  1  branch or jump resolved in EX disagrees with the prediction.
REQ-011 ex_sys  in  1  halting syscall in EX.
REQ-012 go  in  1  resume pulse from the board controls.
REQ-013 run  out  1  global pipeline-register enable.
REQ-014 stall_fd  out  1  hold PC and IF/ID.
REQ-015 bubble  out  1  insert a NOP into ID/EX.
REQ-016 clear_u  out  1  flush IF/ID and ID/EX.
REQ-017 redirection  out  6  forwarding select, latched by ID/EX.
REQ-018 halted  out  1  FSM is in HALT.
REQ-019 cycle_cnt, stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-020 redirection SHALL be combinational from the ID/EX/MEM inputs; bit i SHALL be forced to 0 when its operand's use flag is 0 or its register is 0.
REQ-021 bit0 / bit1 (operand 1 / 2 from result): ex_we & !ex_ld & ex_rw == id_r1 / id_r2.
REQ-022 bit2 / bit3 (operand 1 / 2 from data_in_re): mem_we & mem_rw == id_r1 / id_r2.
REQ-023 bit4 / bit5 (operand 1 / 2 from LO): ex_we_lo & id_lo_r1 / id_lo_r2; bits 4 and 5 SHALL ignore the register-0 rule.
REQ-024 When EX and MEM both match the same operand, the EX bit SHALL be set and the MEM bit SHALL be cleared.
REQ-025 Load-use hazard = ex_ld & ex_we & ex_rw != 0 & ((id_r1_use & ex_rw == id_r1) | (id_r2_use & ex_rw == id_r2)).
REQ-026 On a load-use hazard: stall_fd=1 and bubble=1 for exactly that cycle.
REQ-027 After the stall, MEM-stage forwarding SHALL supply the loaded value; no second bubble is added.
REQ-028 ex_mispredict=1: clear_u=1 for one cycle; stall_fd=0 and bubble=0 that cycle (the flush dominates the load-use hazard).
REQ-029 FSM states: RUN and HALT.
REQ-030 RUN -> HALT on ex_sys & !ex_mispredict.
REQ-031 HALT -> RUN on go; go SHALL be ignored while in RUN.
REQ-032 run = 1 in RUN and 0 in HALT; the transition SHALL take effect in the cycle after ex_sys is sampled.
REQ-033 In HALT: stall_fd, bubble and clear_u SHALL be 0 and all counters SHALL hold.
REQ-034 In the ex_sys cycle itself: run=1, so the syscall advances to MEM.
REQ-035 cycle_cnt SHALL increment every cycle in RUN.
REQ-036 stall_cnt SHALL increment on each bubble cycle.
REQ-037 flush_cnt SHALL increment on each clear_u cycle.
REQ-038 All counters SHALL wrap modulo 2^32.
REQ-039 All control outputs other than run and redirection SHALL be registered-free combinational decodes of the current state and inputs; only the FSM and the counters are sequential.

Reset
REQ-040 rst_n=0 at a clock edge: FSM=RUN and all counters=0, regardless of the current state or any pending go/ex_sys.
REQ-041 While rst_n=0: run=0, stall_fd=0, bubble=0, clear_u=1, so the pipeline registers are flushed.
REQ-042 First edge with rst_n=1: normal operation with run=1.

Verification
REQ-043 EX lw $5, ID add $6,$5,$7 (ex_ld=1, ex_rw=5, id_r1=5) -> bubble=1, stall_fd=1 for one cycle, stall_cnt +1; next cycle mem_rw=5 -> redirection=6'b000100.
REQ-044 ex_rw=mem_rw=3, both writing, id_r2=3 -> redirection=6'b000010; id_r2=0 with the same inputs -> 6'b000000.
REQ-045 ex_mispredict=1 simultaneous with a load-use hazard -> clear_u=1, bubble=0, flush_cnt +1, stall_cnt unchanged.
REQ-046 ex_sys=1 -> next cycle halted=1, run=0, cycle_cnt frozen over 10 cycles; go=1 -> next cycle run=1, cycle_cnt resumes.
REQ-047 rst_n=0 applied while in HALT with go=1 -> halted=0, counters=0, clear_u=1; after release, cycle_cnt=1 one cycle later.
REQ-048 Preload cycle_cnt=32'hFFFFFFFF via a forced run -> next cycle cycle_cnt=0.
